// File: rtl/uart_pkg.sv
// Shared definitions for the UART report transmit path:
// the frame state encoding and the 8N1 framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_STOP_BITS            = 1;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high so every frame starts on a fresh bit boundary.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Baud counter: cleared while idle, wraps after the last cycle of a bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (clear) begin
            count <= {CNT_W{1'b0}};
        end else if (count == LAST) begin
            count <= {CNT_W{1'b0}};
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_end = !clear && (count == LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// Serialises a DATA_BYTES-wide report word as back-to-back 8N1 frames,
// least-significant byte first, on a one-cycle start request.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BYTES   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*DATA_BYTES-1:0] data_in,
    output logic                    tx,
    output logic                    busy,
    output logic                    done
);

    localparam int WORD_W = 8 * DATA_BYTES;
    localparam int BYTE_W = $clog2(DATA_BYTES) + 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(DATA_BYTES - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_e       state;
    uart_state_e       state_next;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_next;
    logic [BYTE_W-1:0] byte_cnt;
    logic [BYTE_W-1:0] byte_next;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_next;
    logic              tx_next;
    logic              busy_next;
    logic              done_next;
    logic              baud_clear;
    logic              bit_end;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            byte_cnt <= {BYTE_W{1'b0}};
            shreg    <= {WORD_W{1'b0}};
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_next;
            byte_cnt <= byte_next;
            shreg    <= shreg_next;
            tx       <= tx_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // Next-state logic; tx is computed one cycle ahead so the pin is driven from a flop.
    // The word shifts right once per data bit, so after eight bits the next byte sits at [7:0].
    always_comb begin
        state_next = state;
        bit_next   = bit_cnt;
        byte_next  = byte_cnt;
        shreg_next = shreg;
        tx_next    = tx;
        busy_next  = busy;
        done_next  = 1'b0;
        baud_clear = 1'b0;
        case (state)
            IDLE: begin
                baud_clear = 1'b1;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                if (start) begin
                    shreg_next = data_in;
                    bit_next   = 3'd0;
                    byte_next  = {BYTE_W{1'b0}};
                    state_next = START_BIT;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_next = DATA_BITS;
                    tx_next    = shreg[0];
                end else begin
                    state_next = START_BIT;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_next   = 3'd0;
                        state_next = STOP_BIT;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        tx_next    = shreg[1];
                    end
                end else begin
                    state_next = DATA_BITS;
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    if (byte_cnt < LAST_BYTE) begin
                        byte_next  = byte_cnt + BYTE_W'(1);
                        state_next = START_BIT;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    state_next = STOP_BIT;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: per-cycle line comparison against
// an 8N1 waveform model built from the report word.
module tb_uart_frame_tx;

    localparam int CPB  = 4;
    localparam int DB   = 2;
    localparam int CPB2 = 2;
    localparam int DB2  = 1;
    localparam int FLEN = 10 * CPB * DB;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        tx, busy, done;
    logic        start2;
    logic [7:0]  data2;
    logic        tx2, busy2, done2;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BYTES(DB)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .tx(tx), .busy(busy), .done(done)
    );

    uart_frame_tx #(.CLKS_PER_BIT(CPB2), .DATA_BYTES(DB2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .data_in(data2),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    // Expected line level per cycle: for each byte LSB-first, start 0, 8 data bits, stop 1.
    function automatic void model_frame(input logic [127:0] d, input int nb, input int cpb);
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            for (int r = 0; r < cpb; r++) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int r = 0; r < cpb; r++) exp_q.push_back(d[8*b+i]);
            for (int r = 0; r < cpb; r++) exp_q.push_back(1'b1);
        end
    endfunction

    task automatic test_reset();
        start = 1'b1; data_in = 16'h1234;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2; rst = 1'b1; #1;
        n_cmp++;
        if ({tx, busy, done} !== 3'b100) begin
            n_err++; $display("FAIL reset_async got=%b exp=100", {tx, busy, done});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx, busy, done, tx2, busy2, done2} !== 6'b100100) begin
                n_err++; $display("FAIL reset_hold k=%0d got=%b exp=100100", k, {tx, busy, done, tx2, busy2, done2});
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int ndone = 0;
        data_in = 16'hA55A; model_frame(128'(data_in), DB, CPB);
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int k = 1; k <= FLEN; k++) begin
            n_cmp++;
            if ({tx, busy} !== {exp_q[k-1], 1'b1}) begin
                n_err++; $display("FAIL basic_tx k=%0d got=%b exp=%b1", k, {tx, busy}, exp_q[k-1]);
            end
            if (done) ndone++;
            @(negedge clk);
        end
        n_cmp++;
        if ({done, busy, tx, ndone} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
            n_err++; $display("FAIL basic_done done=%b busy=%b tx=%b early=%0d exp done=1 busy=0 tx=1 early=0", done, busy, tx, ndone);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL basic_done_width got=%b exp=0", done);
        end
    endtask

    task automatic test_busy_reject();
        int ndone = 0;
        int nbusy = 0;
        data_in = 16'hA55A; model_frame(128'(data_in), DB, CPB);
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int k = 1; k <= FLEN; k++) begin
            n_cmp++;
            if (tx !== exp_q[k-1]) begin
                n_err++; $display("FAIL reject_tx k=%0d got=%b exp=%b", k, tx, exp_q[k-1]);
            end
            if (k == 20) begin start = 1'b1; data_in = 16'hFFFF; end
            if (k == 21) start = 1'b0;
            if (done) ndone++;
            @(negedge clk);
        end
        for (int k = 0; k < FLEN + 10; k++) begin
            if (done) ndone++;
            if (busy) nbusy++;
            @(negedge clk);
        end
        n_cmp++;
        if (ndone != 1 || nbusy != 0) begin
            n_err++; $display("FAIL reject_once done_pulses=%0d busy_after=%0d exp 1/0", ndone, nbusy);
        end
    endtask

    task automatic test_back_to_back();
        data_in = 16'($urandom); model_frame(128'(data_in), DB, CPB);
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int k = 1; k <= FLEN; k++) begin
            n_cmp++;
            if (tx !== exp_q[k-1]) begin
                n_err++; $display("FAIL b2b_first k=%0d got=%b exp=%b", k, tx, exp_q[k-1]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL b2b_done got=%b exp=1", done);
        end
        start = 1'b1; data_in = 16'h0001; model_frame(128'(data_in), DB, CPB);
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= FLEN; k++) begin
            n_cmp++;
            if ({tx, busy, done} !== {exp_q[k-1], 1'b1, 1'b0}) begin
                n_err++; $display("FAIL b2b_second k=%0d got=%b exp=%b10", k, {tx, busy, done}, exp_q[k-1]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_err++; $display("FAIL b2b_second_done got=%b exp=10", {done, busy});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        data_in = 16'($urandom); model_frame(128'(data_in), DB, CPB);
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int k = 1; k < 30; k++) @(negedge clk);
        n_cmp++;
        if (tx !== exp_q[29]) begin
            n_err++; $display("FAIL rstmid_pre got=%b exp=%b", tx, exp_q[29]);
        end
        @(posedge clk); #2; rst = 1'b1; #1;
        n_cmp++;
        if ({tx, busy} !== 2'b10) begin
            n_err++; $display("FAIL rstmid_async got=%b exp=10", {tx, busy});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < FLEN; k++) begin
            if (done || busy || !tx) ndone++;
            @(negedge clk);
        end
        n_cmp++;
        if (ndone != 0) begin
            n_err++; $display("FAIL rstmid_quiet activity_cycles=%0d exp=0", ndone);
        end
        data_in = 16'($urandom); model_frame(128'(data_in), DB, CPB);
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int k = 1; k <= FLEN; k++) begin
            n_cmp++;
            if (tx !== exp_q[k-1]) begin
                n_err++; $display("FAIL rstmid_new k=%0d got=%b exp=%b", k, tx, exp_q[k-1]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL rstmid_new_done got=%b exp=1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        data2 = 8'h80; model_frame(128'(data2), DB2, CPB2);
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        for (int k = 1; k <= 10 * CPB2 * DB2; k++) begin
            n_cmp++;
            if ({tx2, busy2, done2} !== {exp_q[k-1], 1'b1, 1'b0}) begin
                n_err++; $display("FAIL sweep_tx k=%0d got=%b exp=%b10", k, {tx2, busy2, done2}, exp_q[k-1]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({done2, busy2, tx2} !== 3'b101) begin
            n_err++; $display("FAIL sweep_done got=%b exp=101", {done2, busy2, tx2});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            int gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                n_cmp++;
                if ({tx, busy} !== 2'b10) begin
                    n_err++; $display("FAIL rand_idle f=%0d got=%b exp=10", f, {tx, busy});
                end
                @(negedge clk);
            end
            data_in = 16'($urandom); model_frame(128'(data_in), DB, CPB);
            start = 1'b1; @(negedge clk); start = 1'b0;
            data_in = 16'($urandom);
            for (int k = 1; k <= FLEN; k++) begin
                n_cmp++;
                if ({tx, busy} !== {exp_q[k-1], 1'b1}) begin
                    n_err++; $display("FAIL rand_tx f=%0d k=%0d got=%b exp=%b1", f, k, {tx, busy}, exp_q[k-1]);
                end
                @(negedge clk);
            end
            n_cmp++;
            if (done !== 1'b1) begin
                n_err++; $display("FAIL rand_done f=%0d got=%b exp=1", f, done);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; data_in = 16'h0000; data2 = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Transmit end of the periodic UART report path.
- The periodic timer pulses a one-cycle start; this block latches a DATA_BYTES-wide word on that pulse and serialises it as 8N1 UART frames on tx.
- Bytes are sent back-to-back, least-significant byte first.
- Sits between the timer/measurement logic and the board UART pin.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range >= 2.
- DATA_BYTES, 4, bytes per report; legal range 1..16.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request pulse from the timer.
- data_in  input  8*DATA_BYTES  report word; sampled only in the cycle start is accepted.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high from the cycle after acceptance until the final stop bit completes.
- done  output  1  one-cycle pulse when the last stop bit of the last byte ends.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state is cleared immediately on rst assertion, independent of clk.
- Reset values:
  - tx=1, busy=0, done=0.
  - FSM=IDLE; bit, byte and baud counters=0.
  - Shift/hold register=0.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE:
  - tx=1.
  - If start=1, latch data_in into the hold register, clear counters and go to START_BIT.
  - busy and tx=0 appear on the following cycle (one-cycle latency, tx registered).
- START_BIT: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA_BITS.
- DATA_BITS:
  - tx = current byte, LSB first.
  - Each bit is held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP_BIT.
- STOP_BIT:
  - tx=1 for CLKS_PER_BIT cycles.
  - If byte index < DATA_BYTES-1: increment byte index, select the next byte (bits [8k+7:8k]) and go to START_BIT. There is no idle gap between bytes.
  - Else go to IDLE with done=1 for that single cycle and busy=0.
- Frame length: each byte occupies exactly 10*CLKS_PER_BIT cycles. A full report occupies 10*CLKS_PER_BIT*DATA_BYTES cycles of tx activity.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits, wraps 0..CLKS_PER_BIT-1.
  - Bit counter: 3 bits.
  - Byte counter: $clog2(DATA_BYTES)+1 bits.
  - No counter may overflow for any legal parameter value.
- start while busy: ignored; there is no queueing. data_in changes while busy have no effect.
- start in the same cycle done is asserted: accepted, because the FSM is in IDLE that cycle. The next frame's start bit follows with no extra idle.
- start held high for several cycles: a new report begins each time IDLE is reached. The timer guarantees single-cycle pulses.
- Reset mid-frame: tx returns to 1 immediately, busy=0, and no done pulse is issued. The partial frame is abandoned.
- No parity, no flow control, 1 stop bit only.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START_BIT, DATA_BITS, STOP_BIT).
  - Constants UART_DATA_BITS=8 and UART_STOP_BITS=1.
  - Default CLKS_PER_BIT.
- One natural sub-module: uart_baud_tick.
  - Counts 0..CLKS_PER_BIT-1.
  - Outputs a one-cycle bit_end tick.
  - Cleared by the FSM on frame entry.
- Byte sequencing and shifting stay in uart_frame_tx.

Test Plan (CLKS_PER_BIT=4, DATA_BYTES=2 unless stated):
- Reset: assert rst asynchronously mid-cycle -> tx=1, busy=0, done=0 before the next clk edge. Hold 5 cycles -> no change.
- Basic frame: start pulse with data_in=16'hA55A -> tx carries byte 0x5A then 0xA5.
  - Each byte is start 0, data bits LSB first, stop 1, at 4 cycles/bit.
  - busy high for exactly 80 cycles.
  - done pulses once at cycle 80 after acceptance.
- Busy rejection: second start at cycle 20 with data_in=16'hFFFF -> ignored. Serial output is still 0x5A, 0xA5 and done pulses only once.
- Back-to-back: start in the done cycle with data_in=16'h0001 -> the next start bit begins on the next cycle with zero idle gap. Output bytes are 0x01, 0x00.
- Reset mid-frame: rst asserted at cycle 30 of a frame -> tx=1 and busy=0 immediately, no done. A new start after release sends a full correct frame.
- Parameter sweep: CLKS_PER_BIT=2 and DATA_BYTES=1, data 8'h80 -> 20-cycle frame, data bits 0000_0001 in time order, done at cycle 20.
